// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared constants and sizing helpers for the SIPO deserializer
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 5;

    // Bits per frame: data bits plus an optional trailing parity bit.
    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

    // Counter width able to hold 0..WIDTH (parity slot) with headroom.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// rtl/sipo_deserializer_if.sv - serial input / parallel output bundle for the deserializer
interface sipo_deserializer_if #(
    parameter int WIDTH = sipo_pkg::DEFAULT_WIDTH
);
    localparam int CW = sipo_pkg::cnt_width(WIDTH);

    logic             in;
    logic             shift_en;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic [CW-1:0]    bit_cnt;
    logic             parity_err;

    modport master (
        output in, shift_en,
        input  shift_q, data_out, data_valid, bit_cnt, parity_err
    );

    modport slave (
        input  in, shift_en,
        output shift_q, data_out, data_valid, bit_cnt, parity_err
    );
endinterface

// File: rtl/sipo_deserializer_bit_counter.sv
// rtl/sipo_deserializer_bit_counter.sv - modulo-FRAME_LEN bit counter with terminal-count strobe
module frame_bit_counter #(
    parameter int FRAME_LEN = 5,
    parameter int CW        = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o
);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    // Next count: advance on enabled edges, fold back to zero after the last bit.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - parametrised SIPO deserializer top; optional parity via SIPO_PARITY_EN
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter bit FIRST_BIT_LSB = 1'b1
) (
    input  logic clk,
    input  logic reset,
    sipo_deserializer_if.slave bus
);
`ifdef SIPO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
    localparam int CW        = cnt_width(WIDTH);

    logic [CW-1:0]    cnt;
    logic             wrap;
    logic             data_bit_en;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] shift_q_q;
    logic [WIDTH-1:0] shift_q_d;
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;
    logic             data_valid_q;

    frame_bit_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CW        (CW)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .en_i   (bus.shift_en),
        .cnt_o  (cnt),
        .wrap_o (wrap)
    );

    // Shift direction decides where the first bit of a frame ends up.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shifted = bus.in;
        end else if (FIRST_BIT_LSB) begin : g_lsb
            assign shifted = {bus.in, shift_q_q[WIDTH-1:1]};
        end else begin : g_msb
            assign shifted = {shift_q_q[WIDTH-2:0], bus.in};
        end
    endgenerate

`ifdef SIPO_PARITY_EN
    logic parity_err_q;

    // The parity slot samples `in` but never enters the shift register.
    assign data_bit_en = bus.shift_en && (cnt != CW'(WIDTH));

    // Even parity over the completed word plus the parity bit; held until the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else if (wrap) begin
            parity_err_q <= (^shift_q_q) ^ bus.in;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign data_bit_en    = bus.shift_en;
    assign bus.parity_err = 1'b0;
`endif

    // With parity the word is already complete when the parity bit arrives.
    always_comb begin
        shift_q_d  = data_bit_en ? shifted : shift_q_q;
        data_out_d = PARITY_EN ? shift_q_q : shifted;
    end

    // Live shift tap, held output word and one-cycle completion strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            shift_q_q    <= shift_q_d;
            if (wrap) begin
                data_out_q <= data_out_d;
            end
            data_valid_q <= wrap;
        end
    end

    assign bus.shift_q    = shift_q_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.bit_cnt    = cnt;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - self-checking bench: LSB-first and MSB-first instances against a frame model
module tb_sipo_deserializer;
    localparam int W = 5;
`ifdef SIPO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(W)) ifa ();
    sipo_deserializer_if #(.WIDTH(W)) ifb ();

    sipo_deserializer #(.WIDTH(W), .FIRST_BIT_LSB(1'b1)) dut_lsb (.clk(clk), .reset(reset), .bus(ifa));
    sipo_deserializer #(.WIDTH(W), .FIRST_BIT_LSB(1'b0)) dut_msb (.clk(clk), .reset(reset), .bus(ifb));

    // Reference model: bits seen since reset and bits of the current frame.
    bit         hist[$];
    bit         frame[$];
    logic [W-1:0] m_out_lsb, m_out_msb;
    logic       m_valid, m_perr;
    int         m_cnt;

    function automatic logic [W-1:0] tap(input bit lsb);
        logic [W-1:0] v = '0;
        for (int j = 0; j < W && j < hist.size(); j++) begin
            if (lsb) v[W-1-j] = hist[hist.size()-1-j];
            else     v[j]     = hist[hist.size()-1-j];
        end
        return v;
    endfunction

    function automatic logic [W-1:0] word(input bit lsb);
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++) begin
            if (lsb) v[i] = frame[i];
            else     v[W-1-i] = frame[i];
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rst, input bit en, input bit b);
        bit x;
        m_valid = 1'b0;
        if (rst) begin
            hist.delete(); frame.delete();
            m_out_lsb = '0; m_out_msb = '0; m_perr = 1'b0;
        end else if (en) begin
            if (PAR && frame.size() == W) begin
                x = b;
                foreach (frame[i]) x ^= frame[i];
                m_perr = x;
                m_out_lsb = word(1'b1); m_out_msb = word(1'b0);
                m_valid = 1'b1;
                frame.delete();
            end else begin
                frame.push_back(b);
                hist.push_back(b);
                if (hist.size() > W) void'(hist.pop_front());
                if (!PAR && frame.size() == W) begin
                    m_out_lsb = word(1'b1); m_out_msb = word(1'b0);
                    m_valid = 1'b1;
                    frame.delete();
                end
            end
        end
        m_cnt = frame.size();
    endtask

    task automatic step(input bit rst, input bit en, input bit b);
        @(negedge clk);
        reset = rst; ifa.shift_en = en; ifb.shift_en = en; ifa.in = b; ifb.in = b;
        @(posedge clk);
        #1;
        model(rst, en, b);
        chk("lsb_shift_q",    ifa.shift_q,    tap(1'b1));
        chk("msb_shift_q",    ifb.shift_q,    tap(1'b0));
        chk("lsb_data_out",   ifa.data_out,   m_out_lsb);
        chk("msb_data_out",   ifb.data_out,   m_out_msb);
        chk("lsb_data_valid", ifa.data_valid, m_valid);
        chk("msb_data_valid", ifb.data_valid, m_valid);
        chk("lsb_bit_cnt",    ifa.bit_cnt,    m_cnt);
        chk("msb_bit_cnt",    ifb.bit_cnt,    m_cnt);
        chk("lsb_parity_err", ifa.parity_err, m_perr);
        chk("msb_parity_err", ifb.parity_err, m_perr);
    endtask

    task automatic send_frame(input logic [W-1:0] bits_first_at_lsb, input bit par_flip);
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, bits_first_at_lsb[i]);
        if (PAR) step(1'b0, 1'b1, (^bits_first_at_lsb) ^ par_flip);
    endtask

    initial begin
        reset = 1'b1; ifa.in = 1'b0; ifb.in = 1'b0; ifa.shift_en = 1'b0; ifb.shift_en = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);

        // Bits 1,0,1,1,0 in both bit orders.
        send_frame(5'b01101, 1'b0);
        chk("t1_lsb_word", ifa.data_out, 5'h0D);
        chk("t2_msb_word", ifb.data_out, 5'h16);
        chk("t2_msb_tap",  ifb.shift_q,  5'h16);
        chk("t1_cnt_zero", ifa.bit_cnt,  0);
        step(1'b0, 1'b0, 1'b0);

        // Mid-frame enable gap.
        step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0);
        if (PAR) step(1'b0, 1'b1, 1'b1);
        chk("t3_gap_word", ifa.data_out, 5'h0D);

        // Partial frame discarded by reset.
        step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_cnt_after_reset", ifa.bit_cnt, 0);
        send_frame(5'b11111, 1'b0);
        chk("t4_word", ifa.data_out, 5'h1F);

        // Back-to-back frames.
        send_frame(5'h0D, 1'b0);
        chk("t5_first", ifa.data_out, 5'h0D);
        send_frame(5'h12, 1'b0);
        chk("t5_second", ifa.data_out, 5'h12);

        // Parity good then bad.
        send_frame(5'h0D, 1'b0);
        chk("t6_perr_good", ifa.parity_err, 1'b0);
        send_frame(5'h0D, 1'b1);
        chk("t6_perr_bad", ifa.parity_err, PAR);

        // Randomised enables, data and occasional reset.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
